// File: rtl/addbit_pkg.sv
// Shared helpers for the addbit_pipe pipelined adder.
// The ADDBIT_PIPE_OVF_EN macro adds the operand sign bits to the per-stage control payload.
package addbit_pkg;

    function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Width-independent part of a stage payload; the vectors live in the top's stage_t.
    typedef struct packed {
        logic carry;
`ifdef ADDBIT_PIPE_OVF_EN
        logic a_sign;
        logic b_sign;
`endif
    } stage_ctl_t;

endpackage

// File: rtl/addbit_seg.sv
// One carry-chain segment: combinational SEG-bit add with carry in and carry out.
module addbit_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           ci_i,
    output logic [SEG-1:0] sum_o,
    output logic           co_o
);

    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, ci_i};

endmodule

// File: rtl/addbit_pipe.sv
// WIDTH-bit adder whose carry chain is cut into STAGES registered segments with valid/ready.
// Defining ADDBIT_PIPE_OVF_EN adds the two's-complement overflow output ovf.
module addbit_pipe
    import addbit_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef ADDBIT_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SEG = seg_width(WIDTH, STAGES);

    // Partial sum fills from the top and shifts down; remaining operands shift down as consumed.
    typedef struct packed {
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        stage_ctl_t       ctl;
    } stage_t;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] rdy;
    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];

    always_comb begin
        logic r;
        r = !v_q[STAGES-1] | out_ready;
        rdy[STAGES-1] = r;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            r = !v_q[k] | r;
            rdy[k] = r;
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] psum_src;
        logic             c_src;
        logic [SEG-1:0]   seg_sum;
        logic             seg_co;

        if (k == 0) begin : gen_first
            assign v_src[k] = in_valid;
            assign a_src    = a;
            assign b_src    = b;
            assign c_src    = ci;
            assign psum_src = '0;
`ifdef ADDBIT_PIPE_OVF_EN
            assign stage_d[k].ctl.a_sign = a[WIDTH-1];
            assign stage_d[k].ctl.b_sign = b[WIDTH-1];
`endif
        end else begin : gen_next
            assign v_src[k] = v_q[k-1];
            assign a_src    = stage_q[k-1].a_rem;
            assign b_src    = stage_q[k-1].b_rem;
            assign c_src    = stage_q[k-1].ctl.carry;
            assign psum_src = stage_q[k-1].psum;
`ifdef ADDBIT_PIPE_OVF_EN
            assign stage_d[k].ctl.a_sign = stage_q[k-1].ctl.a_sign;
            assign stage_d[k].ctl.b_sign = stage_q[k-1].ctl.b_sign;
`endif
        end

        addbit_seg #(
            .SEG (SEG)
        ) u_seg (
            .a_i   (a_src[SEG-1:0]),
            .b_i   (b_src[SEG-1:0]),
            .ci_i  (c_src),
            .sum_o (seg_sum),
            .co_o  (seg_co)
        );

        assign stage_d[k].psum      = (psum_src >> SEG) | (WIDTH'(seg_sum) << (WIDTH - SEG));
        assign stage_d[k].a_rem     = a_src >> SEG;
        assign stage_d[k].b_rem     = b_src >> SEG;
        assign stage_d[k].ctl.carry = seg_co;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (rdy[k]) begin
                    v_q[k]     <= v_src[k];
                    stage_q[k] <= stage_d[k];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = stage_q[STAGES-1].psum;
    assign co        = stage_q[STAGES-1].ctl.carry;
`ifdef ADDBIT_PIPE_OVF_EN
    assign ovf = (stage_q[STAGES-1].ctl.a_sign == stage_q[STAGES-1].ctl.b_sign) &&
                 (stage_q[STAGES-1].psum[WIDTH-1] != stage_q[STAGES-1].ctl.a_sign);
`endif

endmodule

// File: tb/tb_addbit_pipe.sv
// Directed self-checking bench for addbit_pipe (WIDTH=8, STAGES=2).
// Exercises the ovf output when ADDBIT_PIPE_OVF_EN is defined.
module tb_addbit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       co;
`ifdef ADDBIT_PIPE_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    addbit_pipe #(
        .WIDTH  (8),
        .STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
`ifdef ADDBIT_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Valid result: out_valid=1 with the given carry and sum.
    task automatic chk_res(input string tag, input logic c, input logic [7:0] s);
        chk(tag, {6'b0, out_valid, co, sum}, {6'b0, 1'b1, c, s});
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {15'b0, out_valid}, 16'h0000);
    endtask

    task automatic chk_rdy(input string tag, input logic e);
        chk(tag, {15'b0, in_ready}, {15'b0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        ci       = cv;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("reset_state", {6'b0, out_valid, co, sum}, 16'h0000);
        rst = 1'b0;
        #1;
        chk_rdy("reset_in_ready", 1'b1);

        // Single item, full carry ripple across both segments.
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk_idle("lat_cycle1");
        tick();
        chk_res("lat_cycle2", 1'b1, 8'h00);
        tick();
        chk_idle("lat_after");

        // Back-to-back stream.
        drive(1'b1, 8'h03, 8'h04, 1'b0);
        tick();
        drive(1'b1, 8'h80, 8'h80, 1'b1);
        tick();
        chk_res("stream0", 1'b0, 8'h07);
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        chk_rdy("stream_rdy", 1'b1);
        tick();
        chk_res("stream1", 1'b1, 8'h01);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk_res("stream2", 1'b0, 8'h01);
        tick();
        chk_idle("stream_end");

        // Backpressure: three items offered, two fit.
        out_ready = 1'b0;
        drive(1'b1, 8'h10, 8'h20, 1'b0);
        tick();
        drive(1'b1, 8'h55, 8'h0A, 1'b1);
        chk_rdy("bp_second_rdy", 1'b1);
        tick();
        drive(1'b1, 8'hF0, 8'h20, 1'b0);
        chk_rdy("bp_full", 1'b0);
        chk_res("bp_head", 1'b0, 8'h30);
        tick();
        tick();
        tick();
        chk_rdy("bp_still_full", 1'b0);
        chk_res("bp_hold", 1'b0, 8'h30);
        out_ready = 1'b1;
        #1;
        chk_rdy("bp_release_rdy", 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk_res("bp_drain1", 1'b0, 8'h60);
        tick();
        chk_res("bp_drain2", 1'b1, 8'h10);
        tick();
        chk_idle("bp_empty");

        // Bubble collapse under output stall.
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h01, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk_res("bub_head", 1'b0, 8'h02);
        drive(1'b1, 8'h02, 8'h02, 1'b0);
        chk_rdy("bub_rdy_open", 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk_rdy("bub_rdy_closed", 1'b0);
        chk_res("bub_hold", 1'b0, 8'h02);
        out_ready = 1'b1;
        tick();
        chk_res("bub_second", 1'b0, 8'h04);
        tick();
        chk_idle("bub_empty");

        // Asynchronous reset with two items in flight.
        out_ready = 1'b0;
        drive(1'b1, 8'h05, 8'h05, 1'b0);
        tick();
        drive(1'b1, 8'h06, 8'h06, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk_res("rst_pre", 1'b0, 8'h0A);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {6'b0, out_valid, co, sum}, 16'h0000);
        chk_rdy("rst_rdy", 1'b1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk_rdy("rst_release_rdy", 1'b1);
        tick();
        chk_idle("rst_no_out1");
        tick();
        chk_idle("rst_no_out2");

`ifdef ADDBIT_PIPE_OVF_EN
        drive(1'b1, 8'h7F, 8'h01, 1'b0);
        tick();
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk_res("ovf_pos_sum", 1'b0, 8'h80);
        chk("ovf_pos", {15'b0, ovf}, 16'h0001);
        tick();
        chk_res("ovf_mix_sum", 1'b1, 8'h00);
        chk("ovf_mix", {15'b0, ovf}, 16'h0000);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
